// File: rtl/rs_msg_packer.sv
// Packs a byte stream into fixed 64-entry message blocks for the RS encoder.
// Short blocks are zero-padded (shortened code). Each completed block produces a one-cycle msg_valid pulse.
module rs_msg_packer #(
    parameter int BLOCK_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] msg_out [64],
    output logic       msg_valid,
    output logic [6:0] msg_len
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(BLOCK_BYTES - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [6:0] cnt_r;
    logic [7:0] buf_r [64];
    logic       xfer_s;
    logic       done_s;

    // s_ready is only ever high in FILL, so a transfer implies FILL
    assign xfer_s = s_valid & s_ready;

    // Next-state logic: a block completes on s_last or on its final byte
    always_comb begin
        state_nxt_s = state_r;
        done_s      = 1'b0;
        case (state_r)
            FILL: begin
                if (xfer_s && (s_last || (cnt_r == LAST_IDX))) begin
                    done_s      = 1'b1;
                    state_nxt_s = EMIT;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            EMIT: begin
                state_nxt_s = FILL;
            end
            default: begin
                state_nxt_s = FILL;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Byte buffer, fill counter and registered block outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= 7'd0;
            s_ready   <= 1'b0;
            msg_valid <= 1'b0;
            msg_len   <= 7'd0;
            for (int k = 0; k < 64; k++) begin
                buf_r[k]   <= 8'h00;
                msg_out[k] <= 8'h00;
            end
        end else begin
            s_ready   <= (state_nxt_s == FILL);
            msg_valid <= done_s;

            if (done_s) begin
                cnt_r <= 7'd0;
            end else if (xfer_s) begin
                cnt_r <= cnt_r + 7'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            for (int k = 0; k < 64; k++) begin
                if (xfer_s && (cnt_r == 7'(k))) begin
                    buf_r[k] <= s_data;
                end
            end

            // The completing byte bypasses the buffer so the block is visible one cycle later
            if (done_s) begin
                msg_len <= cnt_r + 7'd1;
                for (int k = 0; k < 64; k++) begin
                    if (7'(k) < cnt_r) begin
                        msg_out[k] <= buf_r[k];
                    end else if (7'(k) == cnt_r) begin
                        msg_out[k] <= s_data;
                    end else begin
                        msg_out[k] <= 8'h00;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_msg_packer.sv
// Randomized scoreboard bench for rs_msg_packer: a block-level model predicts each emitted block.
// A negedge monitor checks the emitted blocks, their latency, held outputs and reset state.
module tb_rs_msg_packer;

    localparam int BB = 64;

    typedef struct packed {
        logic [6:0]   len;
        logic [511:0] data;
        logic [31:0]  cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] msg_out [64];
    logic       msg_valid;
    logic [6:0] msg_len;

    int         n_cmp;
    int         n_fail;
    logic [31:0] cyc;
    bit         model_ready;
    logic [7:0] blk [$];
    exp_t       sbq [$];

    rs_msg_packer #(.BLOCK_BYTES(BB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .msg_out   (msg_out),
        .msg_valid (msg_valid),
        .msg_len   (msg_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, pending=%0d", sbq.size());
        $fatal(1, "watchdog");
    end

    // Model: the accumulated block becomes one expected message, zero-padded to 64 bytes
    task automatic close_block();
        exp_t e;
        e.len  = 7'(blk.size());
        e.data = '0;
        foreach (blk[i]) e.data[8*i +: 8] = blk[i];
        e.cyc  = cyc + 32'd1;
        sbq.push_back(e);
        blk.delete();
    endtask

    task automatic check_ready();
        n_cmp++;
        if (s_ready !== model_ready) begin
            n_fail++;
            $display("FAIL s_ready at cyc %0d: got %b expected %b", cyc, s_ready, model_ready);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit l, input int gap_pct);
        bit done;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            check_ready();
            if (!model_ready) begin
                s_valid     = 1'($urandom_range(0, 1));
                s_data      = 8'($urandom);
                s_last      = 1'($urandom_range(0, 1));
                model_ready = 1'b1;
            end else if (int'($urandom_range(0, 99)) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom_range(0, 1));
            end else begin
                s_valid = 1'b1;
                s_data  = d;
                s_last  = l;
                blk.push_back(d);
                if (l || blk.size() == BB) begin
                    close_block();
                    model_ready = 1'b0;
                end
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_ready();
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom_range(0, 1));
            model_ready = 1'b1;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        s_valid     = 1'b0;
        model_ready = 1'b0;
        blk.delete();
        repeat (n) @(negedge clk);
        #2;
        rst_n       = 1'b1;
        model_ready = 1'b1;
    endtask

    // Monitor: compare every pulse against the scoreboard, and held/reset outputs otherwise
    logic [511:0] act;
    logic [511:0] last_data;
    logic [6:0]   last_len;
    exp_t         e_m;
    always @(negedge clk) begin
        for (int k = 0; k < 64; k++) act[8*k +: 8] = msg_out[k];
        if (!rst_n) begin
            n_cmp++;
            if (msg_valid !== 1'b0 || s_ready !== 1'b0 || msg_len !== 7'd0 || act !== 512'd0) begin
                n_fail++;
                $display("FAIL reset: valid=%b ready=%b len=%0d out=%h, expected all zero",
                         msg_valid, s_ready, msg_len, act);
            end
            last_len  = 7'd0;
            last_data = 512'd0;
        end else if (msg_valid === 1'b1) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL pulse: unexpected msg_valid at cyc %0d, expected none", cyc);
            end else begin
                e_m = sbq.pop_front();
                if (msg_len !== e_m.len) begin
                    n_fail++;
                    $display("FAIL msg_len: got %0d expected %0d", msg_len, e_m.len);
                end
                n_cmp++;
                if (act !== e_m.data) begin
                    n_fail++;
                    $display("FAIL msg_out: got %h expected %h", act, e_m.data);
                end
                n_cmp++;
                if (cyc !== e_m.cyc) begin
                    n_fail++;
                    $display("FAIL latency: pulse at cyc %0d expected %0d", cyc, e_m.cyc);
                end
                last_len  = e_m.len;
                last_data = e_m.data;
            end
        end else begin
            n_cmp++;
            if (msg_valid !== 1'b0 || msg_len !== last_len || act !== last_data) begin
                n_fail++;
                $display("FAIL hold: valid=%b len=%0d out=%h expected valid=0 len=%0d out=%h",
                         msg_valid, msg_len, act, last_len, last_data);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        cyc = 32'd0;
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_last = 1'b0;
        model_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        model_ready = 1'b1;

        for (int i = 0; i < 64; i++) send(8'(i), 1'b0, 0);
        idle(2);

        send(8'hAA, 1'b0, 0);
        send(8'hBB, 1'b0, 0);
        send(8'hCC, 1'b1, 0);
        idle(3);

        for (int i = 0; i < 64; i++) send(8'hFF, 1'b0, 0);
        idle(5);
        send(8'h11, 1'b0, 0);
        send(8'h22, 1'b1, 0);
        idle(2);

        for (int i = 0; i < 10; i++) send(8'($urandom), 1'b0, 20);
        do_reset(2);
        send(8'h5A, 1'b1, 0);
        idle(2);

        for (int i = 0; i < 64; i++) send(8'($urandom), (i == 63), 40);
        idle(3);

        for (int b = 0; b < 20; b++) begin
            int len;
            bit lastf;
            len = int'($urandom_range(1, 64));
            lastf = (len < 64) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++)
                send(8'($urandom), (i == len - 1) ? lastf : 1'b0, (b % 2 == 0) ? 0 : 30);
            if (b % 3 == 0) idle(int'($urandom_range(1, 4)));
        end
        idle(5);

        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL pending: %0d expected blocks never emitted, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
